// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_checker
// Purpose  : Assembles a serial bit stream into DATA_W-bit frames plus one
//            trailing parity bit, checks even/odd parity, counts failures.
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              odd_sel,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              par_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              led
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] C_PAR_IDX = IDX_W'(DATA_W);

    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              xor_q,   xor_d;
    logic              odd_q,   odd_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              done_q,  done_d;
    logic              perr_q,  perr_d;
    logic [ERR_W-1:0]  cnt_q,   cnt_d;
    logic              led_q,   led_d;

    logic w_at_par;
    logic w_fail;

    assign w_at_par = (idx_q == C_PAR_IDX);
    assign w_fail   = ((xor_q ^ in_bit) != odd_q);

    always_comb begin
        idx_d   = idx_q;
        xor_d   = xor_q;
        odd_d   = odd_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        cnt_d   = cnt_q;
        led_d   = led_q;

        // clr takes priority over any bit presented in the same cycle
        if (clr) begin
            idx_d = '0;
            xor_d = 1'b0;
            cnt_d = '0;
            led_d = 1'b0;
        end else if (in_valid) begin
            if (w_at_par) begin
                idx_d  = '0;
                data_d = shift_q;
                done_d = 1'b1;
                perr_d = w_fail;
                if (w_fail) begin
                    led_d = 1'b1;
                    if (cnt_q != {ERR_W{1'b1}}) begin
                        cnt_d = cnt_q + ERR_W'(1);
                    end
                end
            end else begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        shift_d[i] = in_bit;
                    end
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == '0) begin
                    xor_d = in_bit;
                    odd_d = odd_sel;
                end else begin
                    xor_d = xor_q ^ in_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            xor_q   <= 1'b0;
            odd_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            xor_q   <= xor_d;
            odd_q   <= odd_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    assign data_out   = data_q;
    assign frame_done = done_q;
    assign par_err    = perr_q;
    assign err_cnt    = cnt_q;
    assign led        = led_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_checker
// Purpose  : Directed + randomized checks of parity_frame_checker against a
//            frame-level reference model (two instances: ERR_W=8 and ERR_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_checker;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_bit, odd_sel, clr;
    logic [DW-1:0] data_out, s_data;
    logic          frame_done, par_err, led, s_done, s_perr, s_led;
    logic [7:0]    err_cnt;
    logic [1:0]    s_cnt;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(DW), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .odd_sel(odd_sel), .clr(clr), .data_out(data_out),
        .frame_done(frame_done), .par_err(par_err), .err_cnt(err_cnt), .led(led)
    );

    parity_frame_checker #(.DATA_W(DW), .ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .odd_sel(odd_sel), .clr(clr), .data_out(s_data),
        .frame_done(s_done), .par_err(s_perr), .err_cnt(s_cnt), .led(s_led)
    );

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    // Reference model: pending data bits of the current frame plus results
    bit            q[$];
    bit            odd_m;
    logic [DW-1:0] data_m;
    bit            done_m, perr_m, led_m;
    int unsigned   cnt8_m, cnt2_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("frame_done", 32'(frame_done), 32'(done_m));
        chk("par_err",    32'(par_err),    32'(perr_m));
        chk("data_out",   32'(data_out),   32'(data_m));
        chk("err_cnt",    32'(err_cnt),    cnt8_m);
        chk("led",        32'(led),        32'(led_m));
        chk("sat_err_cnt", 32'(s_cnt),     cnt2_m);
        chk("sat_par_err", 32'(s_perr),    32'(perr_m));
    endtask

    task automatic model_reset();
        q.delete();
        odd_m = 1'b0; data_m = '0; done_m = 1'b0; perr_m = 1'b0;
        led_m = 1'b0; cnt8_m = 0; cnt2_m = 0;
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        logic [DW-1:0] word;
        bit            fail;
        in_valid = v; in_bit = b; clr = c;
        done_m = 1'b0; perr_m = 1'b0;
        if (c) begin
            q.delete();
            cnt8_m = 0; cnt2_m = 0; led_m = 1'b0;
        end else if (v) begin
            if (q.size() == DW) begin
                word = '0;
                for (int i = 0; i < DW; i++) word[i] = q[i];
                fail = ((($countones(word) + int'(b)) % 2) != int'(odd_m));
                data_m = word; done_m = 1'b1; perr_m = fail;
                if (fail) begin
                    led_m = 1'b1;
                    if (cnt8_m < 255) cnt8_m++;
                    if (cnt2_m < 3) cnt2_m++;
                end
                q.delete();
            end else begin
                if (q.size() == 0) odd_m = odd_sel;
                q.push_back(b);
            end
        end
        @(posedge clk); #1;
        if (frame_done === 1'b1) frames_seen++;
        check_all();
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_bit = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("rst_frame_done", 32'(s_done), 32'd0);
        chk("rst_led_sat", 32'(s_led), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Sends one frame; optional random idle gaps and odd_sel toggling mid-frame
    task automatic send_frame(input logic [DW-1:0] d, input logic p,
                              input bit gaps, input bit toggle_odd);
        for (int i = 0; i < DW; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom), 1'b0);
            step(1'b1, d[i], 1'b0);
            if (toggle_odd) odd_sel = 1'($urandom);
        end
        if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom), 1'b0);
        step(1'b1, p, 1'b0);
    endtask

    function automatic logic good_par(input logic [DW-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    initial begin
        logic [DW-1:0] d;
        int            base;
        odd_sel = 1'b0;
        do_reset();
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Even frame, good parity
        odd_sel = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("even_a5_data", 32'(data_out), 32'hA5);
        step(1'b0, 1'b0, 1'b0);

        // Odd mode: failure then pass
        odd_sel = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("odd_fail_perr", 32'(par_err), 32'd1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        chk("odd_pass_led", 32'(led), 32'd1);

        // Gapped frame then 3 back-to-back frames
        base = frames_seen;
        odd_sel = 1'($urandom);
        d = 8'($urandom);
        send_frame(d, 1'($urandom), 1'b1, 1'b1);
        for (int f = 0; f < 3; f++) begin
            d = 8'($urandom);
            odd_sel = 1'($urandom);
            send_frame(d, 1'($urandom), 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("b2b_frame_count", 32'(frames_seen - base), 32'd4);

        // Saturation of the 2-bit counter
        step(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 5; f++) begin
            d = 8'($urandom);
            odd_sel = 1'($urandom);
            send_frame(d, ~good_par(d, odd_sel), 1'b0, 1'b0);
        end
        chk("sat_final", 32'(s_cnt), 32'd3);

        // clr after 4 data bits, then good frame
        base = frames_seen;
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'b1, 1'b1);
        odd_sel = 1'b0;
        send_frame(8'h5A, good_par(8'h5A, 1'b0), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_restart_count", 32'(frames_seen - base), 32'd1);
        chk("clr_restart_data", 32'(data_out), 32'h5A);

        // Reset mid-frame, then good frame
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0);
        do_reset();
        base = frames_seen;
        odd_sel = 1'b1;
        send_frame(8'hC3, good_par(8'hC3, 1'b1), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_restart_count", 32'(frames_seen - base), 32'd1);

        // clr coincident with the parity bit
        base = frames_seen;
        for (int i = 0; i < DW; i++) step(1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_par_no_done", 32'(frames_seen - base), 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            odd_sel = 1'($urandom);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 60) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
